pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. It sits beside the IF/ID and ID/EX registers and drives their stall, flush and bubble inputs, including the `BranchBubble` input of the ID/EX register. Hazards it resolves:
- load-use data hazards;
- taken branches/jumps resolved in EX;
- CP0 exception/ERET redirects;
- structural hazards on the shared multi-cycle HI/LO multiply/divide unit, which it also sequences.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_md_seq.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 72 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multiply/divide sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

  localparam int DEF_MULT_CYCLES = 4;
  localparam int DEF_DIV_CYCLES  = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Sequencer for the shared HI/LO multiply/divide unit: counts the execution
// cycles of an accepted operation, then spends one DONE cycle writing HI/LO.
module md_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only moves down while nonzero in RUN, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          state_d = MD_RUN;
          cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MD_IDLE);
    done = (state_q == MD_DONE);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble controller for the five-stage pipeline: resolves load-use,
// redirect and HI/LO structural hazards and launches the multiply/divide unit.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_ra,
  input  logic [4:0] id_rb,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic       id_hilo_rd,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic [4:0] ex_rw,
  input  logic       ex_regWr,
  input  logic [1:0] ex_memtoreg,
  input  logic       ex_branch_taken,
  input  logic       ex_exc,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       BranchBubble,
  output logic       md_busy,
  output logic       md_done
);

  logic load_use;
  logic md_haz;
  logic redirect;
  logic md_accept;

  always_comb begin
    load_use = ex_regWr && (ex_memtoreg == MEMTOREG_LOAD) && (ex_rw != 5'd0) &&
               ((id_uses_ra && (id_ra == ex_rw)) || (id_uses_rb && (id_rb == ex_rw)));
    md_haz   = md_busy && (id_hilo_rd || id_md_start);
    redirect = ex_exc || ex_branch_taken;
    // A flushed or stalled mult/div must not start the unit.
    md_accept = id_md_start && !redirect && !md_haz && !load_use;
  end

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    BranchBubble = 1'b0;
    if (redirect) begin
      ifid_flush   = 1'b1;
      BranchBubble = 1'b1;
    end else if (load_use || md_haz) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      BranchBubble = 1'b1;
    end
  end

  md_seq #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .accept(md_accept),
    .is_div(id_md_div),
    .busy  (md_busy),
    .done  (md_done)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle-level model predicts all six
// outputs per cycle; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;
  localparam int W      = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_ra = '0, id_rb = '0, ex_rw = '0;
  logic       id_uses_ra = 1'b0, id_uses_rb = 1'b0, id_hilo_rd = 1'b0;
  logic       id_md_start = 1'b0, id_md_div = 1'b0, ex_regWr = 1'b0;
  logic [1:0] ex_memtoreg = '0;
  logic       ex_branch_taken = 1'b0, ex_exc = 1'b0;
  logic       pc_stall, ifid_stall, ifid_flush, BranchBubble, md_busy, md_done;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_hilo_rd(id_hilo_rd), .id_md_start(id_md_start), .id_md_div(id_md_div),
    .ex_rw(ex_rw), .ex_regWr(ex_regWr), .ex_memtoreg(ex_memtoreg),
    .ex_branch_taken(ex_branch_taken), .ex_exc(ex_exc),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .BranchBubble(BranchBubble), .md_busy(md_busy), .md_done(md_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int mon_cycle = 0;

  // Reference model: cycles the unit will still be occupied, counting this one.
  int   md_left = 0;
  logic prev_rst_n = 1'b0;
  logic prev_accept = 1'b0;
  logic prev_div = 1'b0;
  logic last_stall = 1'b0;

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                      input logic ura, input logic urb, input logic hilo,
                      input logic mds, input logic mdd, input logic [4:0] rw,
                      input logic rwr, input logic [1:0] mtr, input logic br,
                      input logic exc);
    logic busy, done, lu, mh, red, pc, ifs, fl, bub, acc;
    @(posedge clk);
    if (!prev_rst_n)       md_left = 0;
    else if (prev_accept)  md_left = (prev_div ? DIV_N : MULT_N) + 1;
    else if (md_left > 0)  md_left = md_left - 1;
    #1;
    rst_n = rst; id_ra = ra; id_rb = rb; id_uses_ra = ura; id_uses_rb = urb;
    id_hilo_rd = hilo; id_md_start = mds; id_md_div = mdd; ex_rw = rw;
    ex_regWr = rwr; ex_memtoreg = mtr; ex_branch_taken = br; ex_exc = exc;
    busy = (md_left > 0);
    done = (md_left == 1);
    lu  = rwr && (mtr == 2'b01) && (rw != 0) && ((ura && ra == rw) || (urb && rb == rw));
    mh  = busy && (hilo || mds);
    red = br || exc;
    pc = 0; ifs = 0; fl = 0; bub = 0;
    if (red) begin fl = 1; bub = 1; end
    else if (lu || mh) begin pc = 1; ifs = 1; bub = 1; end
    acc = mds && !red && !mh && !lu;
    exp_q.push_back({pc, ifs, fl, bub, busy, done});
    last_stall  = pc;
    prev_rst_n  = rst;
    prev_accept = acc;
    prev_div    = mdd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {pc_stall, ifid_stall, ifid_flush, BranchBubble, md_busy, md_done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d got {pc,ifs,flush,bub,busy,done}=%b exp=%b",
                 mon_cycle, got_v, exp_v);
      end
      mon_cycle++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    idle(0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    idle(2);

    // lw $8 in EX, add reading $8 in ID: one-cycle stall, then the load leaves EX
    step(1, 8, 3, 1, 1, 0, 0, 0, 8, 1, 2'b01, 0, 0);
    step(1, 8, 3, 1, 1, 0, 0, 0, 9, 1, 2'b00, 0, 0);
    // same with destination $0: no stall
    step(1, 0, 3, 1, 1, 0, 0, 0, 0, 1, 2'b01, 0, 0);
    // rb match only, and unused-source match
    step(1, 4, 8, 1, 1, 0, 0, 0, 8, 1, 2'b01, 0, 0);
    step(1, 8, 8, 0, 0, 0, 0, 0, 8, 1, 2'b01, 0, 0);
    // taken branch coincident with load-use: redirect wins
    step(1, 8, 3, 1, 1, 0, 0, 0, 8, 1, 2'b01, 1, 0);
    idle(1);

    // mult, then mflo issued next cycle: stalls until the unit is free
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    guard = 0;
    do begin
      step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0);
      guard++;
    end while (last_stall && guard < 64);
    idle(2);

    // div followed immediately by mult
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0);
    guard = 0;
    do begin
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
      guard++;
    end while (last_stall && guard < 64);
    idle(8);

    // exception coincident with mult start: no accept
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 1);
    idle(2);
    // exception during RUN: operation completes
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    idle(6);

    // reset mid-divide (counter around 10): abandoned, no done pulse
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0);
    idle(21);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    idle(35);

    // randomized traffic biased toward register matches and HI/LO activity
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
